// File: rtl/fp_acc_seq.sv
// Serial floating-point packet reducer: folds a valid/ready operand stream into
// one sum by issuing one addition at a time to an external fp_add (start/done).
module fp_acc_seq #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              add_start,
  output logic [DATA_W-1:0] add_op_a,
  output logic [DATA_W-1:0] add_op_b,
  input  logic              add_done,
  input  logic [DATA_W-1:0] add_res,
  output logic              busy,
  output logic              err
);

  // The attached fp_add must share this word layout; catch a mismatch at elaboration.
  if (EXP_W < 2 || EXP_W > DATA_W - 2) begin : g_bad_exp_w
    $error("fp_acc_seq: EXP_W does not fit inside DATA_W");
  end

  typedef enum logic [1:0] {IDLE, WAIT_IN, WAIT_RES, OUT} state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               last_reg;
  logic               add_start_reg;
  logic [DATA_W-1:0]  add_op_a_reg, add_op_b_reg;
  logic [DATA_W-1:0]  out_data_reg;
  logic [CNT_W-1:0]   out_count_reg;
  logic               err_reg;
  logic               in_hs, out_hs;
  logic [CNT_W-1:0]   cnt_inc;

  assign in_ready  = (state_reg == IDLE) || (state_reg == WAIT_IN);
  assign out_valid = (state_reg == OUT);
  assign busy      = (state_reg != IDLE);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign cnt_inc   = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

  assign add_start = add_start_reg;
  assign add_op_a  = add_op_a_reg;
  assign add_op_b  = add_op_b_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;
  assign err       = err_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (in_hs) state_next = in_last ? OUT : WAIT_IN;
      WAIT_IN:  if (in_hs) state_next = WAIT_RES;
      WAIT_RES: if (add_done) state_next = last_reg ? OUT : WAIT_IN;
      OUT:      if (out_hs) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      last_reg      <= 1'b0;
      add_start_reg <= 1'b0;
      add_op_a_reg  <= '0;
      add_op_b_reg  <= '0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      add_start_reg <= 1'b0;
      // A done pulse with no addition in flight is a protocol fault; never folded in.
      if (add_done && state_reg != WAIT_RES) err_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (in_hs) begin
            acc_reg <= in_data;
            cnt_reg <= CNT_W'(1);
            if (in_last) begin
              out_data_reg  <= in_data;
              out_count_reg <= CNT_W'(1);
            end
          end
        end
        WAIT_IN: begin
          if (in_hs) begin
            add_op_a_reg  <= acc_reg;
            add_op_b_reg  <= in_data;
            add_start_reg <= 1'b1;
            last_reg      <= in_last;
            cnt_reg       <= cnt_inc;
          end
        end
        WAIT_RES: begin
          if (add_done) begin
            acc_reg <= add_res;
            if (last_reg) begin
              out_data_reg  <= add_res;
              out_count_reg <= cnt_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_acc_seq.sv
// Bench for fp_acc_seq: packet vectors with a 5-cycle fp_add stand-in, plus timing,
// backpressure, stray-done and mid-packet reset sequences.
module tb_fp_acc_seq;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, add_start, add_done, busy, err;
  logic [DW-1:0] out_data, add_op_a, add_op_b, add_res;
  logic [CW-1:0] out_count;
  logic          stray_done = 1'b0;

  always #5 clk = ~clk;

  fp_acc_seq #(.DATA_W(DW), .EXP_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .add_start(add_start), .add_op_a(add_op_a), .add_op_b(add_op_b),
    .add_done(add_done), .add_res(add_res), .busy(busy), .err(err)
  );

  // fp_add stand-in: exact sums for the operand pairs used here, order-sensitive
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h0) return b;
    if (b == 32'h0) return a;
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
      {32'h40400000, 32'h40400000}: return 32'h40C00000; // 3+3
      {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2
      {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1
      {32'h40800000, 32'h40800000}: return 32'h41000000; // 4+4
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  logic [4:0]    pipe;
  logic [DW-1:0] pa, pb;
  always @(posedge clk) begin
    if (rst) pipe <= '0;
    else begin
      pipe <= {pipe[3:0], add_start};
      if (add_start) begin
        pa <= add_op_a;
        pb <= add_op_b;
      end
    end
  end
  assign add_done = pipe[4] | stray_done;
  assign add_res  = pipe[4] ? fadd(pa, pb) : '0;

  int cyc = 0;
  int acc_cyc[$];
  int start_cyc[$];
  int outv_cyc[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
    if (add_start) start_cyc.push_back(cyc);
    if (out_valid) outv_cyc.push_back(cyc);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [3:0][31:0] d;
    logic [2:0]       n;
    logic [31:0]      sum;
    logic [15:0]      cnt;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input logic [31:0] s, input logic [15:0] c);
    vec_t v;
    v.d   = {e3, e2, e1, e0};
    v.n   = 3'(n);
    v.sum = s;
    v.cnt = c;
    return v;
  endfunction

  // Feed a packet with in_valid held high; returns at #1 after the last accept.
  task automatic send(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) begin
      int t;
      in_valid = 1'b1;
      in_data  = v.d[i];
      in_last  = (i == int'(v.n) - 1);
      t = 0;
      while (!in_ready && t < 50) begin
        tick();
        t++;
      end
      if (t >= 50) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1 within 50 cycles");
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv(input string name, input logic [31:0] s, input logic [15:0] c);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_out_valid_timeout: got 0 expected 1 within 50 cycles", name);
    end
    chk({name, "_sum"}, out_data, s);
    chk({name, "_count"}, 32'(out_count), 32'(c));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = mk(3, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 32'h40C00000, 16'd3);
    vecs[1] = mk(1, 32'hC0A00000, 0, 0, 0, 32'hC0A00000, 16'd1);
    vecs[2] = mk(2, 32'h40000000, 32'h40000000, 0, 0, 32'h40800000, 16'd2);
    vecs[3] = mk(2, 32'h3F800000, 32'h3F800000, 0, 0, 32'h40000000, 16'd2);
    vecs[4] = mk(4, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000, 16'd4);
    vecs[5] = mk(2, 32'h00000000, 32'h3F800000, 0, 0, 32'h3F800000, 16'd2);

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_add_start", 32'(add_start), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);

    // cycle-exact timing for {1,2,3}
    begin
      int base, a0, s0, o0;
      a0 = acc_cyc.size();
      s0 = start_cyc.size();
      o0 = outv_cyc.size();
      base = cyc;
      send(vecs[0]);
      recv("timing", vecs[0].sum, vecs[0].cnt);
      chk("timing_accept0", 32'(acc_cyc[a0] - base), 32'd0);
      chk("timing_accept1", 32'(acc_cyc[a0 + 1] - base), 32'd1);
      chk("timing_accept2", 32'(acc_cyc[a0 + 2] - base), 32'd8);
      chk("timing_start0", 32'(start_cyc[s0] - base), 32'd2);
      chk("timing_start1", 32'(start_cyc[s0 + 1] - base), 32'd9);
      chk("timing_out_valid", 32'(outv_cyc[o0] - base), 32'd15);
    end

    // single element: out_valid on the very next cycle, no addition
    begin
      int s0;
      s0 = start_cyc.size();
      send(vecs[1]);
      chk("single_next_cycle_valid", 32'(out_valid), 32'd1);
      recv("single", vecs[1].sum, vecs[1].cnt);
      chk("single_no_start", 32'(start_cyc.size() - s0), 32'd0);
    end

    // table of packets
    for (int k = 0; k < 6; k++) begin
      int s0;
      s0 = start_cyc.size();
      send(vecs[k]);
      recv($sformatf("vec%0d", k), vecs[k].sum, vecs[k].cnt);
      chk($sformatf("vec%0d_adds", k), 32'(start_cyc.size() - s0), 32'(int'(vecs[k].n) - 1));
    end

    // output backpressure
    begin
      logic [31:0] d0;
      logic [15:0] c0;
      int t, bad;
      send(vecs[3]);
      t = 0;
      while (!out_valid && t < 50) begin
        tick();
        t++;
      end
      d0 = out_data;
      c0 = out_count;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (!out_valid || out_data !== d0 || out_count !== c0 || in_ready) bad++;
        tick();
      end
      chk("bp_stable_cycles_bad", 32'(bad), 32'd0);
      chk("bp_held_sum", out_data, 32'h40000000);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_busy_after_hs", 32'(busy), 32'd0);
      chk("bp_out_valid_after_hs", 32'(out_valid), 32'd0);
    end

    // stray add_done while IDLE
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    chk("stray_err_set", 32'(err), 32'd1);
    send(vecs[2]);
    recv("stray_pkt", 32'h40800000, 16'd2);
    chk("stray_err_sticky", 32'(err), 32'd1);

    // reset while WAIT_RES of a 3-element packet
    in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b0;
    tick();
    in_data = 32'h40000000;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err_cleared", 32'(err), 32'd0);
    send(vecs[3]);
    recv("midrst_pkt", 32'h40000000, 16'd2);
    chk("midrst_no_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fp_acc_seq.md
Name: fp_acc_seq

Overview:
Sequential floating-point reduction controller placed directly in front of fp_add. It accepts a packet of IEEE-754 operands over a valid/ready stream, terminated by in_last. It serially sums the packet by issuing one addition at a time to an external fp_add instance (start/done interface, 5-cycle latency) and feeding each result back as the next accumulator. The packet sum and element count are presented on a valid/ready output stream.

Parameters:
DATA_W, 32, floating-point word width; must match the attached fp_add
EXP_W, 8, exponent width; must match the attached fp_add
CNT_W, 16, width of the element counter and out_count

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input operand valid
in_ready  out  1  block can accept an operand this cycle
in_data  in  DATA_W  input operand
in_last  in  1  qualifies in_data as the final element of the packet
out_valid  out  1  packet sum available
out_ready  in  1  downstream accepts the sum
out_data  out  DATA_W  packet sum
out_count  out  CNT_W  number of elements in the packet
add_start  out  1  one-cycle start pulse to fp_add
add_op_a  out  DATA_W  fp_add operand A (the accumulator)
add_op_b  out  DATA_W  fp_add operand B (the new element)
add_done  in  1  fp_add done pulse
add_res  in  DATA_W  fp_add result, valid with add_done
busy  out  1  high whenever state is not IDLE
err  out  1  sticky flag: add_done received outside WAIT_RES

Behaviour:
- Reset (clk, rst synchronous active-high): state=IDLE; acc, cnt, add_op_a, add_op_b, out_data and out_count are all 0; add_start=0, out_valid=0, err=0. The same rst also drives fp_add, so no stale add_done arrives after reset.
- An input handshake occurs when in_valid & in_ready. An output handshake occurs when out_valid & out_ready.
- in_ready = (state==IDLE) | (state==WAIT_IN). It is combinational from state only, with no dependence on in_valid.
- State IDLE:
  - On handshake: acc<=in_data, cnt<=1.
  - If in_last, go to OUT with out_data<=in_data and out_count<=1. A single-element packet passes through bit-exact with no addition.
  - Otherwise go to WAIT_IN.
- State WAIT_IN:
  - On handshake: add_op_a<=acc, add_op_b<=in_data, add_start<=1 for exactly one cycle, last_q<=in_last, cnt<=cnt+1 (saturating at 2^CNT_W-1). Go to WAIT_RES.
  - add_start rises in the cycle after the handshake.
- State WAIT_RES:
  - in_ready=0.
  - add_op_a and add_op_b are held stable until add_done.
  - On add_done: acc<=add_res.
  - If last_q, go to OUT with out_data<=add_res and out_count<=cnt. Otherwise go to WAIT_IN.
- State OUT:
  - out_valid=1. out_data and out_count are held stable until the output handshake.
  - On handshake, go to IDLE; out_valid deasserts the next cycle.
- Latency with fp_add (5 cycles start->done):
  - Input handshake in WAIT_IN at cycle t -> add_start at t+1 -> add_done at t+6 -> block is back in WAIT_IN (or OUT) at t+7.
  - Throughput is one element per 7 cycles after the first.
- err is set when add_done=1 and state!=WAIT_RES; it is cleared only by rst. A stray add_done never modifies acc.
- No floating-point special-case handling: zeros, infinities and NaNs are passed to fp_add unmodified. The addition order is left-to-right: ((e0+e1)+e2)+…
- Reset mid-operation (any state) returns to the reset values immediately on the next edge. A partial packet is discarded.

Test Plan:
- Reset: hold rst for 3 cycles -> in_ready=1, busy=0, out_valid=0, err=0, add_start=0, out_data=0.
- Packet {1.0=0x3F800000, 2.0=0x40000000, 3.0=0x40400000(last)} with in_valid continuous from cycle 0 and real fp_add attached:
  - accepts at cycles 0, 1, 8;
  - add_start at cycles 2 and 9;
  - out_valid at cycle 15 with out_data=0x40C00000 (6.0), out_count=3.
- Single-element packet 0xC0A00000(last) -> add_start never asserted; out_valid the next cycle with out_data=0xC0A00000, out_count=1.
- Output backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid, out_data and out_count remain stable and in_ready=0. Raising out_ready gives busy=0 the cycle after the handshake.
- Stray add_done pulse while IDLE -> err=1 and stays high; a following packet {2.0, 2.0(last)} still yields out_data=0x40800000.
- Assert rst in WAIT_RES of a 3-element packet -> the next cycle shows state IDLE, in_ready=1, out_valid=0. A new packet {1.0, 1.0(last)} yields 0x40000000, out_count=2.
